// File: rtl/fwd_store_data_hist_pkg.sv
// Shared definitions for the store-data forwarding slice: default widths,
// forward-source encodings and the layout of one history entry.
package fwd_store_data_hist_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 3;

  // fwd_src encoding: 0 no forward, 1 live WB, 2+k history entry k
  localparam int FWD_SRC_NONE      = 0;
  localparam int FWD_SRC_WB        = 1;
  localparam int FWD_SRC_HIST_BASE = 2;

  // One retired register write at the default widths; the buffer keeps
  // the same {valid, reg, data} layout at its own parameterised widths.
  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] regn;
    logic [DATA_W_DEF-1:0] data;
  } hist_entry_t;

endpackage

// File: rtl/fwd_store_data_hist_buf.sv
// DEPTH-entry shift buffer of retired register writes. Entry 0 is newest.
// clr beats shift_en; reset is asynchronous and clears every entry.
module fwd_hist_buf
  import fwd_store_data_hist_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           shift_en,
  input  logic                           clr,
  input  logic [REG_AW-1:0]              new_reg,
  input  logic [DATA_W-1:0]              new_data,
  output logic [DEPTH-1:0]               valid,
  output logic [DEPTH-1:0][REG_AW-1:0]   regs,
  output logic [DEPTH-1:0][DATA_W-1:0]   data
);

  // Clear, shift-in-at-0 or hold the whole history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      regs  <= '0;
      data  <= '0;
    end else if (clr) begin
      valid <= '0;
    end else if (shift_en) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        valid[k] <= valid[k-1];
        regs[k]  <= regs[k-1];
        data[k]  <= data[k-1];
      end
      valid[0] <= 1'b1;
      regs[0]  <= new_reg;
      data[0]  <= new_data;
    end
  end

endmodule

// File: rtl/fwd_store_data_hist.sv
// Store-data forwarding into MEM from the live WB result and from a short
// history of retired writes, with flush/stall and a saturating hit counter.
module fwd_store_data_hist
  import fwd_store_data_hist_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_AW    = REG_AW_DEF,
  parameter int DEPTH     = 2,
  parameter int LOAD_ONLY = 1,
  parameter int CNT_W     = 8,
  localparam int SRC_W    = $clog2(DEPTH + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_we,
  input  logic              wb_is_load,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mem_is_store,
  input  logic [REG_AW-1:0] mem_src_reg,
  input  logic [DATA_W-1:0] mem_reg_data,
  output logic [DATA_W-1:0] mem_store_data,
  output logic              fwd_hit,
  output logic [SRC_W-1:0]  fwd_src,
  output logic [CNT_W-1:0]  fwd_cnt
);

  logic                         cap;
  logic [DEPTH-1:0]             h_valid;
  logic [DEPTH-1:0][REG_AW-1:0] h_regs;
  logic [DEPTH-1:0][DATA_W-1:0] h_data;

  // A WB write is a forwarding candidate; in load-only mode ALU writes are ignored
  assign cap = wb_we & ((LOAD_ONLY != 0) ? wb_is_load : 1'b1);

  fwd_hist_buf #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .shift_en (cap & ~stall & ~flush),
    .clr      (flush),
    .new_reg  (wb_reg),
    .new_data (wb_data),
    .valid    (h_valid),
    .regs     (h_regs),
    .data     (h_data)
  );

  // Priority lookup: scan oldest to newest, then live WB, so the newest match wins
  always_comb begin
    mem_store_data = mem_reg_data;
    fwd_hit        = 1'b0;
    fwd_src        = SRC_W'(FWD_SRC_NONE);
    if (mem_is_store) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (h_valid[k] && (h_regs[k] == mem_src_reg)) begin
          mem_store_data = h_data[k];
          fwd_hit        = 1'b1;
          fwd_src        = SRC_W'(FWD_SRC_HIST_BASE + k);
        end
      end
      if (cap && (wb_reg == mem_src_reg)) begin
        mem_store_data = wb_data;
        fwd_hit        = 1'b1;
        fwd_src        = SRC_W'(FWD_SRC_WB);
      end
    end
  end

  // Count forwarded stores that actually advance; saturate at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_cnt <= '0;
    end else if (fwd_hit && !stall && !flush && (fwd_cnt != {CNT_W{1'b1}})) begin
      fwd_cnt <= fwd_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_store_data_hist.sv
// Directed bench for fwd_store_data_hist. Three instances share stimulus:
// dut (LOAD_ONLY=1), dut_any (LOAD_ONLY=0), dut_c2 (CNT_W=2).
module tb_fwd_store_data_hist;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        wb_we, wb_is_load, mem_is_store;
  logic [2:0]  wb_reg, mem_src_reg;
  logic [15:0] wb_data, mem_reg_data;

  logic [15:0] sd_a, sd_b, sd_c;
  logic        hit_a, hit_b, hit_c;
  logic [1:0]  src_a, src_b, src_c;
  logic [7:0]  cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  int n_checks = 0;
  int n_err    = 0;

  // clock / reset
  always #5 clk = ~clk;

  fwd_store_data_hist dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .wb_we(wb_we), .wb_is_load(wb_is_load), .wb_reg(wb_reg), .wb_data(wb_data),
    .mem_is_store(mem_is_store), .mem_src_reg(mem_src_reg), .mem_reg_data(mem_reg_data),
    .mem_store_data(sd_a), .fwd_hit(hit_a), .fwd_src(src_a), .fwd_cnt(cnt_a)
  );

  fwd_store_data_hist #(.LOAD_ONLY(0)) dut_any (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .wb_we(wb_we), .wb_is_load(wb_is_load), .wb_reg(wb_reg), .wb_data(wb_data),
    .mem_is_store(mem_is_store), .mem_src_reg(mem_src_reg), .mem_reg_data(mem_reg_data),
    .mem_store_data(sd_b), .fwd_hit(hit_b), .fwd_src(src_b), .fwd_cnt(cnt_b)
  );

  fwd_store_data_hist #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .wb_we(wb_we), .wb_is_load(wb_is_load), .wb_reg(wb_reg), .wb_data(wb_data),
    .mem_is_store(mem_is_store), .mem_src_reg(mem_src_reg), .mem_reg_data(mem_reg_data),
    .mem_store_data(sd_c), .fwd_hit(hit_c), .fwd_src(src_c), .fwd_cnt(cnt_c)
  );

  // driver tasks
  task automatic set_wb(input logic we, input logic ld, input logic [2:0] r, input logic [15:0] d);
    wb_we = we; wb_is_load = ld; wb_reg = r; wb_data = d;
  endtask

  task automatic set_mem(input logic st, input logic [2:0] r, input logic [15:0] d);
    mem_is_store = st; mem_src_reg = r; mem_reg_data = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // store-data outputs of the main instance in one go
  task automatic chk_fwd(input string tag, input logic [15:0] d, input logic h, input logic [1:0] s);
    chk({tag, ".data"}, {16'h0, sd_a}, {16'h0, d});
    chk({tag, ".hit"},  {31'h0, hit_a}, {31'h0, h});
    chk({tag, ".src"},  {30'h0, src_a}, {30'h0, s});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_wb(1'b0, 1'b0, 3'd0, 16'h0);
    set_mem(1'b1, 3'd3, 16'hBEEF);
    #2;
    chk_fwd("reset_passthru", 16'hBEEF, 1'b0, 2'd0);
    chk("reset_cnt", {24'h0, cnt_a}, 32'd0);
    next_cycle();
    rst = 1'b0;

    // live WB load R3 forwards, then the same value from history entry 0
    set_wb(1'b1, 1'b1, 3'd3, 16'h1234); set_mem(1'b1, 3'd3, 16'hDEAD); #1;
    chk_fwd("live_r3", 16'h1234, 1'b1, 2'd1);
    next_cycle();
    set_wb(1'b0, 1'b0, 3'd0, 16'h0); #1;
    chk_fwd("hist0_r3", 16'h1234, 1'b1, 2'd2);
    next_cycle();
    chk("cnt_after_two", {24'h0, cnt_a}, 32'd2);

    // priority: R2=1 then R2=2 captured; live R2=3 under stall, then history
    set_mem(1'b0, 3'd0, 16'h0);
    set_wb(1'b1, 1'b1, 3'd2, 16'h0001); next_cycle();
    set_wb(1'b1, 1'b1, 3'd2, 16'h0002); next_cycle();
    stall = 1'b1;
    set_wb(1'b1, 1'b1, 3'd2, 16'h0003); set_mem(1'b1, 3'd2, 16'h0000); #1;
    chk_fwd("prio_live", 16'h0003, 1'b1, 2'd1);
    next_cycle();
    stall = 1'b0;
    set_wb(1'b0, 1'b0, 3'd0, 16'h0); #1;
    chk_fwd("prio_newest_hist", 16'h0002, 1'b1, 2'd2);
    next_cycle();
    chk("cnt_stall_skipped", {24'h0, cnt_a}, 32'd3);

    // eviction: R1 reaches entry 1, then falls off
    set_mem(1'b0, 3'd0, 16'h0);
    set_wb(1'b1, 1'b1, 3'd1, 16'hAAAA); next_cycle();
    set_wb(1'b1, 1'b1, 3'd4, 16'h4444); next_cycle();
    set_wb(1'b1, 1'b1, 3'd5, 16'h5555); set_mem(1'b1, 3'd1, 16'h5555); #1;
    chk_fwd("evict_entry1", 16'hAAAA, 1'b1, 2'd3);
    next_cycle();
    set_wb(1'b0, 1'b0, 3'd0, 16'h0); #1;
    chk_fwd("evict_gone", 16'h5555, 1'b0, 2'd0);
    next_cycle();

    // ALU write: ignored in load-only mode, forwarded/captured otherwise
    set_wb(1'b1, 1'b0, 3'd6, 16'h7777); set_mem(1'b1, 3'd6, 16'h0BAD); #1;
    chk_fwd("alu_loadonly", 16'h0BAD, 1'b0, 2'd0);
    chk("alu_any.data", {16'h0, sd_b}, 32'h7777);
    chk("alu_any.src",  {30'h0, src_b}, 32'd1);
    next_cycle();
    set_wb(1'b0, 1'b0, 3'd0, 16'h0); #1;
    chk_fwd("alu_not_captured", 16'h0BAD, 1'b0, 2'd0);
    chk("alu_any_captured.src", {30'h0, src_b}, 32'd2);
    next_cycle();

    // flush with a simultaneous capture: both R3 copies are gone
    set_mem(1'b0, 3'd0, 16'h0);
    set_wb(1'b1, 1'b1, 3'd3, 16'h3333); next_cycle();
    set_wb(1'b0, 1'b0, 3'd0, 16'h0); set_mem(1'b1, 3'd3, 16'hCCCC); #1;
    chk_fwd("pre_flush_r3", 16'h3333, 1'b1, 2'd2);
    next_cycle();
    flush = 1'b1;
    set_wb(1'b1, 1'b1, 3'd3, 16'h9999); set_mem(1'b0, 3'd0, 16'h0);
    next_cycle();
    flush = 1'b0;
    set_wb(1'b0, 1'b0, 3'd0, 16'h0); set_mem(1'b1, 3'd3, 16'hCCCC); #1;
    chk_fwd("post_flush_r3", 16'hCCCC, 1'b0, 2'd0);
    chk("cnt_before_stall", {24'h0, cnt_a}, 32'd5);
    next_cycle();

    // three stalled cycles: live forward works, history and counter frozen
    set_mem(1'b0, 3'd0, 16'h0);
    set_wb(1'b1, 1'b1, 3'd7, 16'h7007); next_cycle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_wb(1'b1, 1'b1, 3'd7, 16'hFFFF); set_mem(1'b1, 3'd7, 16'h0000); #1;
      chk_fwd($sformatf("stall_live%0d", i), 16'hFFFF, 1'b1, 2'd1);
      next_cycle();
      chk($sformatf("stall_cnt%0d", i), {24'h0, cnt_a}, 32'd5);
    end
    stall = 1'b0;
    set_wb(1'b0, 1'b0, 3'd0, 16'h0); #1;
    chk_fwd("stall_hist_kept", 16'h7007, 1'b1, 2'd2);

    // async reset mid-cycle with cnt=5 and a valid entry
    #1 rst = 1'b1;
    #1;
    chk("async_rst_cnt", {24'h0, cnt_a}, 32'd0);
    chk_fwd("async_rst_no_hist", 16'h0000, 1'b0, 2'd0);
    next_cycle();
    rst = 1'b0;

    // five live forwards: 8-bit counter climbs, 2-bit counter sticks at 3
    for (int i = 0; i < 5; i++) begin
      set_wb(1'b1, 1'b1, 3'd0, 16'h0100 + 16'(i)); set_mem(1'b1, 3'd0, 16'h0); #1;
      next_cycle();
      chk($sformatf("sat_c2_%0d", i), {30'h0, cnt_c}, (i < 3) ? 32'(i + 1) : 32'd3);
      chk($sformatf("cnt8_%0d", i), {24'h0, cnt_a}, 32'(i + 1));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
